// File: rtl/ps2_cmd_pkg.sv
// Shared definitions for the PS/2 command controller: scancodes, command codes,
// parser state type and the make-code to command lookup.
package ps2_cmd_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_ERR_LO   = 8'h00;
    localparam logic [7:0] SC_ERR_HI   = 8'hFF;

    localparam logic [7:0] SC_KEY_1    = 8'h16;
    localparam logic [7:0] SC_KEY_2    = 8'h1E;
    localparam logic [7:0] SC_KEY_3    = 8'h26;
    localparam logic [7:0] SC_KEY_4    = 8'h25;
    localparam logic [7:0] SC_KEY_R    = 8'h2D;
    localparam logic [7:0] SC_KEY_G    = 8'h34;
    localparam logic [7:0] SC_KEY_B    = 8'h32;
    localparam logic [7:0] SC_KP_PLUS  = 8'h79;
    localparam logic [7:0] SC_KP_MINUS = 8'h7B;
    localparam logic [7:0] SC_KEY_F    = 8'h2B;
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;

    typedef enum logic [3:0] {
        CMD_1     = 4'h0,
        CMD_2     = 4'h1,
        CMD_3     = 4'h2,
        CMD_4     = 4'h3,
        CMD_R     = 4'h4,
        CMD_G     = 4'h5,
        CMD_B     = 4'h6,
        CMD_UP    = 4'h7,
        CMD_DOWN  = 4'h8,
        CMD_LEFT  = 4'h9,
        CMD_RIGHT = 4'hA,
        CMD_PLUS  = 4'hB,
        CMD_MINUS = 4'hC,
        CMD_F     = 4'hD,
        CMD_NONE  = 4'hE
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    function automatic cmd_t map_make(input logic ext, input logic [7:0] code);
        cmd_t result;
        result = CMD_NONE;
        if (!ext) begin
            case (code)
                SC_KEY_1:    result = CMD_1;
                SC_KEY_2:    result = CMD_2;
                SC_KEY_3:    result = CMD_3;
                SC_KEY_4:    result = CMD_4;
                SC_KEY_R:    result = CMD_R;
                SC_KEY_G:    result = CMD_G;
                SC_KEY_B:    result = CMD_B;
                SC_KP_PLUS:  result = CMD_PLUS;
                SC_KP_MINUS: result = CMD_MINUS;
                SC_KEY_F:    result = CMD_F;
                default:     result = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_UP:    result = CMD_UP;
                SC_DOWN:  result = CMD_DOWN;
                SC_LEFT:  result = CMD_LEFT;
                SC_RIGHT: result = CMD_RIGHT;
                default:  result = CMD_NONE;
            endcase
        end
        return result;
    endfunction

    // Keyboard status/response bytes that must never be read as key presses.
    function automatic logic is_status_byte(input logic [7:0] code);
        return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_ECHO) ||
               (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Command queue with a registered head output; reads CMD_NONE while empty.
module ps2_cmd_fifo
    import ps2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] data,
    output logic [3:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, count_next;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (!do_push && do_pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= CMD_NONE;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            count  <= count_next;
            // The only entry left is the one being written this edge: bypass memory.
            if (count_next == '0)
                head <= CMD_NONE;
            else if (do_push && count_next == CW'(1))
                head <= data;
            else
                head <= mem[rd_next];
        end
    end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 set-2 scancode parser that turns key presses into queued 4-bit commands.
//   state      | meaning
//   ST_IDLE    | waiting for a make code or a prefix byte
//   ST_EXT     | E0 seen, next byte is an extended make (or F0)
//   ST_BRK     | F0 seen, next byte is a released key
//   ST_EXT_BRK | E0 F0 seen, next byte is a released extended key
module ps2_cmd_ctrl
    import ps2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scanValid,
    input  logic [7:0] scanCode,
    output logic       cmdValid,
    input  logic       cmdReady,
    output logic [3:0] cmdCode,
    output logic       overflow
);

    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_TC = TW'(PREFIX_TIMEOUT - 1);

    ps2_state_t    state;
    logic [TW-1:0] timer;
    logic [8:0]    held_key;
    logic          held_vld;

    logic          is_make, is_break, key_ext;
    logic [8:0]    key;
    cmd_t          mapped;
    logic          is_repeat, push, pop;
    logic          fifo_full, fifo_empty;

    always_comb begin
        is_make  = 1'b0;
        is_break = 1'b0;
        key_ext  = 1'b0;
        if (scanValid) begin
            case (state)
                ST_IDLE:
                    is_make = (scanCode != SC_EXT) && (scanCode != SC_BREAK) &&
                              !is_status_byte(scanCode);
                ST_EXT: begin
                    is_make = (scanCode != SC_EXT) && (scanCode != SC_BREAK);
                    key_ext = 1'b1;
                end
                ST_BRK:
                    is_break = (scanCode != SC_EXT) && (scanCode != SC_BREAK);
                ST_EXT_BRK: begin
                    is_break = (scanCode != SC_EXT) && (scanCode != SC_BREAK);
                    key_ext  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign key       = {key_ext, scanCode};
    assign mapped    = map_make(key_ext, scanCode);
    assign is_repeat = held_vld && (held_key == key);
    assign push      = is_make && (mapped != CMD_NONE) && !is_repeat;
    assign pop       = cmdValid && cmdReady;
    assign cmdValid  = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            held_key <= '0;
            held_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && fifo_full && !pop;

            // Held key tracks the press even when the queue drops the command.
            if (push) begin
                held_key <= key;
                held_vld <= 1'b1;
            end else if (is_break && held_vld && held_key == key) begin
                held_vld <= 1'b0;
            end

            if (scanValid) begin
                timer <= '0;
                case (state)
                    ST_IDLE:
                        if (scanCode == SC_EXT)
                            state <= ST_EXT;
                        else if (scanCode == SC_BREAK)
                            state <= ST_BRK;
                    ST_EXT:
                        if (scanCode == SC_BREAK)
                            state <= ST_EXT_BRK;
                        else if (scanCode != SC_EXT)
                            state <= ST_IDLE;
                    ST_BRK, ST_EXT_BRK:
                        if (scanCode != SC_EXT && scanCode != SC_BREAK)
                            state <= ST_IDLE;
                    default:
                        state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Stalled prefix: give up on the sequence rather than misparse later bytes.
                if (timer == TIMER_TC) begin
                    state <= ST_IDLE;
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    ps2_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .data (mapped),
        .head (cmdCode),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule
